// File: rtl/sprite_pkg.sv
// Shared frame geometry and types for the sprite blit write engine.
package sprite_pkg;
    localparam int IMG_W  = 320;
    localparam int IMG_H  = 240;
    localparam int ADDR_W = 19;

    typedef logic [3:0] pixel_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} blit_state_t;
endpackage

// File: rtl/sprite_addr_gen.sv
// Rectangle walker: latches the command, steps col/row in raster order and
// reports the RAM address, off-screen clip and last-pixel flags for the current pixel.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int IMG_W  = sprite_pkg::IMG_W,
    parameter int IMG_H  = sprite_pkg::IMG_H,
    parameter int ADDR_W = sprite_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              advance,
    input  logic [8:0]        x_in,
    input  logic [7:0]        y_in,
    input  logic [8:0]        w_in,
    input  logic [7:0]        h_in,
    output logic [ADDR_W-1:0] addr,
    output logic              clip,
    output logic              last
);
    logic [8:0]        x_q, x_d, w_q, w_d, col_q, col_d;
    logic [7:0]        y_q, y_d, h_q, h_d, row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [9:0]        sx, sy;
    logic              col_last;

    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;

        // Screen coordinates kept 10 bits wide so off-screen pixels never wrap.
        sx       = {1'b0, x_q} + {1'b0, col_q};
        sy       = {2'b00, y_q} + {2'b00, row_q};
        col_last = (col_q == w_q - 9'd1);
        last     = col_last && (row_q == h_q - 8'd1);
        clip     = (sx >= 10'(IMG_W)) || (sy >= 10'(IMG_H));
        addr     = row_base_q + ADDR_W'(x_q) + ADDR_W'(col_q);

        if (init) begin
            x_d        = x_in;
            y_d        = y_in;
            w_d        = w_in;
            h_d        = h_in;
            col_d      = '0;
            row_d      = '0;
            row_base_d = ADDR_W'(y_in) * ADDR_W'(IMG_W);
        end else if (advance) begin
            if (col_last) begin
                col_d      = '0;
                row_d      = row_q + 8'd1;
                row_base_d = row_base_q + ADDR_W'(IMG_W);
            end else begin
                col_d = col_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
        end
    end
endmodule

// File: rtl/sprite_blit_writer.sv
// Packed 4bpp byte stream to RAM write port, one pixel per cycle, with
// off-screen clipping and optional transparent-colour skipping.
module sprite_blit_writer
    import sprite_pkg::*;
#(
    parameter int     IMG_W            = sprite_pkg::IMG_W,
    parameter int     IMG_H            = sprite_pkg::IMG_H,
    parameter int     ADDR_W           = sprite_pkg::ADDR_W,
    parameter logic [3:0] TRANSPARENT  = 4'h0,
    parameter bit     SKIP_TRANSPARENT = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [8:0]        x,
    input  logic [7:0]        y,
    input  logic [8:0]        w,
    input  logic [7:0]        h,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] write_address,
    output logic [3:0]        wr_data
);
    blit_state_t       state_q, state_d;
    logic [7:0]        buf_q, buf_d;
    logic              buf_valid_q, buf_valid_d;
    logic              phase_q, phase_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    pixel_t            data_q, data_d;

    logic              init, advance, clip, last;
    logic [ADDR_W-1:0] pix_addr;
    pixel_t            pix;

    sprite_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_addr_gen (
        .clk     (Clk),
        .rst     (Reset),
        .init    (init),
        .advance (advance),
        .x_in    (x),
        .y_in    (y),
        .w_in    (w),
        .h_in    (h),
        .addr    (pix_addr),
        .clip    (clip),
        .last    (last)
    );

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        phase_d     = phase_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        init        = 1'b0;
        advance     = 1'b0;

        pix      = phase_q ? buf_q[3:0] : buf_q[7:4];
        in_ready = (state_q == RUN) && (!buf_valid_q || (phase_q && !last));

        case (state_q)
            IDLE: begin
                if (start) begin
                    init        = 1'b1;
                    buf_valid_d = 1'b0;
                    state_d     = (w == 9'd0 || h == 8'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (buf_valid_q) begin
                    advance = 1'b1;
                    we_d    = !clip && !(SKIP_TRANSPARENT && pix == TRANSPARENT);
                    addr_d  = pix_addr;
                    data_d  = pix;
                    if (last) begin
                        // Odd pixel count: the unused low nibble is dropped here.
                        buf_valid_d = 1'b0;
                        state_d     = DONE;
                    end else if (phase_q) begin
                        buf_valid_d = 1'b0;
                    end else begin
                        phase_d = 1'b1;
                    end
                end
                // Refill overrides the drain above so a byte lands back-to-back.
                if (in_valid && in_ready) begin
                    buf_d       = in_data;
                    buf_valid_d = 1'b1;
                    phase_d     = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            phase_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            phase_q     <= phase_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign we            = we_q;
    assign write_address = addr_q;
    assign wr_data       = data_q;
endmodule

// File: tb/tb_sprite_blit_writer.sv
// Directed and randomized blits checked against a raster-order pixel model.
module tb_sprite_blit_writer;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [8:0]  x, w;
    logic [7:0]  y, h;
    logic        busy, done, in_valid, in_ready, we;
    logic [7:0]  in_data;
    logic [18:0] write_address;
    logic [3:0]  wr_data;

    sprite_blit_writer dut (
        .Clk(Clk), .Reset(Reset), .start(start), .x(x), .y(y), .w(w), .h(h),
        .busy(busy), .done(done), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .write_address(write_address), .wr_data(wr_data)
    );

    always #5 Clk = ~Clk;

    int vectors = 0, miscompares = 0;
    logic [7:0] bq[$];
    int exp_q[$], got_q[$];
    int first_we, last_we, done_cyc, ndone, consumed, busy0, done_we;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected writes: walk pixels in raster order straight from the rules.
    task automatic model(input int cx, input int cy, input int cw, input int ch);
        exp_q.delete();
        for (int i = 0; i < cw * ch; i++) begin
            logic [7:0] b;
            int nib, col, row;
            b   = bq[i / 2];
            nib = (i % 2 == 0) ? int'(b[7:4]) : int'(b[3:0]);
            col = i % cw;
            row = i / cw;
            if (cx + col < 320 && cy + row < 240 && nib != 0)
                exp_q.push_back((((cy + row) * 320 + cx + col) << 4) | nib);
        end
    endtask

    task automatic rand_bytes(input int n);
        bq.delete();
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b[7:4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            b[3:0] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            bq.push_back(b);
        end
    endtask

    // mode 0: continuous, 1: valid 1,0,0 pattern, 2: random valid,
    // 3: pattern plus a stray start mid-command. rst_after>0 leaves after that many writes.
    task automatic run_cmd(input int cx, input int cy, input int cw, input int ch,
                           input int mode, input int rst_after);
        int n, idx, budget;
        bit fin, v;
        n = bq.size(); idx = 0; fin = 0;
        budget = 64 * n + 50;
        got_q.delete();
        first_we = -1; last_we = -1; done_cyc = -1; ndone = 0; done_we = 0; busy0 = 0;
        start = 1'b1; x = cx[8:0]; y = cy[7:0]; w = cw[8:0]; h = ch[7:0]; in_valid = 1'b0;
        @(posedge Clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < budget && !fin; cyc++) begin
            case (mode)
                0:       v = 1'b1;
                2:       v = 1'($urandom_range(0, 1));
                default: v = (cyc % 3 == 0);
            endcase
            in_valid = v && (idx < n);
            in_data  = (idx < n) ? bq[idx] : 8'h00;
            if (mode == 3 && cyc == 4) begin
                start = 1'b1; x = 9'd0; y = 8'd0; w = 9'd1; h = 8'd1;
            end else begin
                start = 1'b0;
            end
            if (cyc == 0) busy0 = int'(busy);
            @(negedge Clk);
            if (we) begin
                got_q.push_back(int'({write_address, wr_data}));
                if (first_we < 0) first_we = cyc;
                last_we = cyc;
            end
            if (done) begin
                ndone++; done_cyc = cyc; done_we = int'(we); fin = 1'b1;
            end
            if (in_valid && in_ready) idx++;
            if (rst_after > 0 && got_q.size() == rst_after) begin
                consumed = idx; in_valid = 1'b0; start = 1'b0;
                return;
            end
            @(posedge Clk); #1;
        end
        in_valid = 1'b0; start = 1'b0; consumed = idx;
        if (!fin) check("timeout_done", 0, 1);
    endtask

    task automatic verify(input string tag, input int cx, input int cy, input int cw, input int ch);
        model(cx, cy, cw, ch);
        check({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_write"}, got_q[i], exp_q[i]);
        check({tag, "_bytes"}, consumed, (cw * ch + 1) / 2);
        check({tag, "_ndone"}, ndone, 1);
        check({tag, "_idle_after"}, int'(busy), 0);
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; x = '0; y = '0; w = '0; h = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(in_ready), 0);
        check("rst_we", int'(we), 0);
        check("rst_addr", int'(write_address), 0);
        check("rst_data", int'(wr_data), 0);
        Reset = 1'b0;
        @(posedge Clk); #1;

        bq = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_cmd(10, 20, 4, 2, 0, 0);
        verify("basic", 10, 20, 4, 2);
        check("basic_busy_c1", busy0, 1);
        check("basic_first_we", first_we, 2);
        check("basic_last_we", last_we, 9);
        check("basic_done_cyc", done_cyc, 9);
        check("basic_done_we", done_we, 1);
        check("basic_addr0", got_q.size() > 0 ? got_q[0] : -1, (6410 << 4) | 1);

        bq = '{8'hA1, 8'hB2};
        run_cmd(0, 0, 3, 1, 0, 0);
        verify("odd", 0, 0, 3, 1);

        bq = '{8'h9A, 8'hBC, 8'hDE, 8'hF1};
        run_cmd(318, 239, 4, 2, 0, 0);
        verify("clip", 318, 239, 4, 2);
        check("clip_addr_last", got_q.size() == 2 ? got_q[1] : -1, (76799 << 4) | 4'hA);

        bq = '{8'h05, 8'h00, 8'h50};
        run_cmd(5, 5, 6, 1, 0, 0);
        verify("transp", 5, 5, 6, 1);

        bq.delete();
        run_cmd(3, 3, 0, 2, 0, 0);
        check("zero_done_cyc", done_cyc, 0);
        check("zero_nwrites", got_q.size(), 0);
        check("zero_bytes", consumed, 0);

        bq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        run_cmd(100, 50, 4, 3, 3, 0);
        verify("gaps_stray_start", 100, 50, 4, 3);

        bq = '{8'h12, 8'h34, 8'h56, 8'h78};
        run_cmd(10, 20, 4, 2, 0, 3);
        Reset = 1'b1;
        #1;
        check("midrst_we", int'(we), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(in_ready), 0);
        check("midrst_addr", int'(write_address), 0);
        @(posedge Clk); #1;
        check("midrst_done", int'(done), 0);
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("midrst_still_idle", int'(busy), 0);
        run_cmd(10, 20, 4, 2, 0, 0);
        verify("after_rst", 10, 20, 4, 2);

        for (int t = 0; t < 8; t++) begin
            int cx, cy, cw, ch;
            cx = $urandom_range(0, 330);
            cy = $urandom_range(0, 245);
            cw = $urandom_range(1, 12);
            ch = $urandom_range(1, 6);
            rand_bytes((cw * ch + 1) / 2);
            run_cmd(cx, cy, cw, ch, t % 3, 0);
            verify("rand", cx, cy, cw, ch);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sprite_blit_writer.md
# sprite_blit_writer

Write-side engine for the 4-bit-per-pixel 320×240 frame/background RAMs. Accepts a rectangle command (x, y, w, h), consumes a packed pixel byte stream (two pixels per byte, high nibble first) over a valid/ready handshake, and drives the RAM write port (`we`, `write_address`, `wr_data`) one pixel per cycle. Performs row-major address generation, off-screen clipping and optional transparent-colour skipping. It sits between the stream source and the RAM's write port; rendering reads stay on the RAM's read port.

## Interface
- `IMG_W`, 320, frame width in pixels (row stride)
- `IMG_H`, 240, frame height in pixels
- `ADDR_W`, 19, RAM address width
- `TRANSPARENT`, 4'h0, colour index treated as transparent
- `SKIP_TRANSPARENT`, 1, when 1, transparent pixels are consumed but not written
- `Clk`  in  1  single clock; all logic on posedge
- `Reset`  in  1  asynchronous, active-high reset
- `start`  in  1  command strobe; sampled only in IDLE
- `x`, `y`  in  9, 8  top-left pixel of the rectangle; latched on accepted `start`
- `w`, `h`  in  9, 8  rectangle size; latched on accepted `start`
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle pulse at command completion
- `in_valid`  in  1  source has a byte
- `in_data`  in  8  packed pixels: [7:4] first, [3:0] second
- `in_ready`  out  1  engine accepts `in_data` this cycle
- `we`  out  1  RAM write enable
- `write_address`  out  ADDR_W  RAM write address
- `wr_data`  out  4  RAM write data

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: `start`=1 latches x,y,w,h, clears col/row, sets row_base = y*IMG_W; goes to RUN, or straight to DONE if w==0 or h==0 (no bytes consumed).
- RUN: one 8-bit holding buffer with `buf_valid` and `phase` (0=high nibble, 1=low).
  - Handshake on `in_valid && in_ready` loads buffer, `phase`=0.
  - Each cycle with `buf_valid`: process current nibble at (col,row); advance col; on col==w-1 wrap col=0, row+1, row_base += IMG_W.
  - Buffer consumed after phase 1, or after phase 0 if that pixel was the last (odd w*h: final low nibble discarded).
  - `in_ready` = RUN && (!buf_valid || (phase==1 && pixel not last)). Gives 1 pixel/cycle sustained.
  - Last pixel (col==w-1, row==h-1) processed → DONE.
- Pixel write: address = row_base + x + col; write suppressed (`we`=0, pixel still consumed) if x+col ≥ IMG_W, y+row ≥ IMG_H, or (SKIP_TRANSPARENT && nibble==TRANSPARENT).
- Arithmetic: x+col and y+row in 10 bits, compared unsigned before truncation; no wrap onto the next row.
- DONE: `done`=1 for one cycle, then IDLE. `start` outside IDLE is ignored.
- Stream stalls (`in_valid`=0) insert idle cycles with `we`=0; no pixels lost.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `in_ready`=0, `we`=0, `write_address`=0, `wr_data`=0, buffer empty.
- `we`, `write_address`, `wr_data` registered: a pixel processed in cycle N appears on the write port in cycle N+1, for exactly one cycle.
- `start` at cycle 0 → `busy`, `in_ready` at cycle 1; byte accepted cycle 1 → first write at cycle 3; second nibble write at cycle 4.
- `done` coincides with the final pixel's write cycle; IDLE the cycle after. Earliest next `start` accepted in that IDLE cycle.
- w or h ==0: `done` at cycle 1, no `we`.
- Reset mid-command: immediate return to IDLE, `we` deasserted, buffered byte dropped, no `done`.

## Structure
- Package `sprite_pkg`: `IMG_W`, `IMG_H`, `ADDR_W`, `pixel_t` (logic [3:0]), `blit_state_t` enum {IDLE, RUN, DONE}.
- Sub-module `sprite_addr_gen`: col/row counters, incremental row_base, clip flag, last-pixel flag; top level holds FSM, buffer, handshake and output registers.

## Test plan
- x=10,y=20,w=4,h=2, bytes 12 34 56 78, in_valid always 1 → writes at 6410..6413 = 1,2,3,4 and 6730..6733 = 5,6,7,8; 8 consecutive `we` cycles; `done` with last write.
- w=3,h=1, bytes A1 B2 → 3 writes (A,1,B); only 2 bytes accepted; nibble 2 never written.
- x=318,y=239,w=4,h=2 → only (318,239),(319,239) written (76798, 76799); 4 bytes still consumed; `done` pulses.
- Bytes 05 00 50 with SKIP_TRANSPARENT=1, w=6,h=1 → `we` only for pixels 1 and 4 (value 5).
- in_valid toggling 1,0,0,1… → identical write contents as continuous stream, `we` gaps only; `start` during RUN ignored.
- Reset asserted after 3 writes of 8 → all outputs at reset values next edge, no `done`; fresh command afterwards completes normally.
